ram_dp: RTL and testbench

- Parametrised dual-port synchronous RAM for the simulation bench; successor to the single-port scalable RAM model.
- Generalises data width, byte-lane write enables and access wait states.
- Adds a clear-on-reset initialisation sequencer, a defined out-of-range read value and a defined write-collision policy.
- Port A connects to the CPU memory backbone; port B connects to a DMA/debug agent.

---
 rtl/ram_dp_pkg.sv | 22 ++
 rtl/ram_dp_if.sv | 25 ++
 rtl/ram_dp_port_ctrl.sv | 69 ++++++
 rtl/ram_dp.sv | 175 +++++++++++++++++
 tb/tb_ram_dp.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_dp_pkg.sv
`default_nettype none
// =============================================================================
// ram_dp_pkg : shared state types and sizing helpers for the dual-port RAM
// Rev 1.0
// =============================================================================
package ram_dp_pkg;

  localparam int WCNT_W = 4;

  typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} top_state_t;
  typedef enum logic [0:0] {P_IDLE = 1'b0, P_WAIT = 1'b1} port_state_t;

  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int depth_of(input int mem_size, input int data_w);
    return mem_size / bytes_of(data_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_dp_if.sv
`default_nettype none
// =============================================================================
// ram_dp_if : one RAM access port (address, byte enables, data, ready)
// Rev 1.0
// =============================================================================
interface ram_dp_if #(
  parameter int ADDR_MSB = 6,
  parameter int DATA_W   = 16
);
  import ram_dp_pkg::*;

  localparam int BYTES = bytes_of(DATA_W);

  logic [ADDR_MSB:0] addr;
  logic              cen;
  logic [BYTES-1:0]  wen;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              ready;

  modport master (output addr, cen, wen, din, input dout, ready);
  modport slave  (input addr, cen, wen, din, output dout, ready);

endinterface
`default_nettype wire

// File: rtl/ram_dp_port_ctrl.sv
`default_nettype none
// =============================================================================
// ram_dp_port_ctrl : per-port wait-state FSM producing ready and commit
// Rev 1.0
// =============================================================================
module ram_dp_port_ctrl
  import ram_dp_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_cen,
  output logic o_ready,
  output logic o_commit
);

  localparam logic [WCNT_W-1:0] C_WAIT = WCNT_W'(WAIT_STATES);

  port_state_t       r_state;
  port_state_t       w_state_nxt;
  logic [WCNT_W-1:0] r_wcnt;
  logic [WCNT_W-1:0] w_wcnt_nxt;
  logic [WCNT_W-1:0] w_wcnt_dec;

  // Ready tracks the post-decrement count so an access costs N+1 cycles.
  assign w_wcnt_dec = r_wcnt - WCNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst || !i_run) begin
      r_state <= P_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    o_ready     = 1'b0;
    if (i_run) begin
      case (r_state)
        P_IDLE: begin
          if (WAIT_STATES == 0) begin
            o_ready = 1'b1;
          end else if (!i_cen) begin
            w_state_nxt = P_WAIT;
            w_wcnt_nxt  = C_WAIT;
          end
        end
        P_WAIT: begin
          o_ready    = (w_wcnt_dec == '0);
          w_wcnt_nxt = w_wcnt_dec;
          if (i_cen || o_ready) begin
            w_state_nxt = P_IDLE;
          end
        end
        default: w_state_nxt = P_IDLE;
      endcase
    end
  end

  assign o_commit = o_ready & ~i_cen;

endmodule
`default_nettype wire

// File: rtl/ram_dp.sv
`default_nettype none
// =============================================================================
// ram_dp : dual-port byte-lane RAM with clear-on-reset and wait states
// Rev 1.0 -- optional collision flag via RAM_DP_COLLISION_CHK_EN
// =============================================================================
module ram_dp
  import ram_dp_pkg::*;
#(
  parameter int ADDR_MSB    = 6,
  parameter int MEM_SIZE    = 256,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic     ram_clk,
  input  logic     ram_rst,
  ram_dp_if.slave  ram_a,
  ram_dp_if.slave  ram_b,
  output logic     ram_init_busy,
  output logic     ram_coll_err
);

  localparam int BYTES = bytes_of(DATA_W);
  localparam int DEPTH = depth_of(MEM_SIZE, DATA_W);
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEPTH - 1);

  top_state_t        r_top;
  top_state_t        w_top_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [DATA_W-1:0] r_a_dout;
  logic [DATA_W-1:0] r_b_dout;

  logic              w_run;
  logic              w_a_ready;
  logic              w_b_ready;
  logic              w_a_commit;
  logic              w_b_commit;
  logic [ADDR_MSB:0] w_a_addr;
  logic [ADDR_MSB:0] w_b_addr;
  logic              w_a_inr;
  logic              w_b_inr;
  logic              w_a_wr;
  logic              w_b_wr;
  logic              w_same;
  logic [CNT_W-1:0]  w_a_idx;
  logic [CNT_W-1:0]  w_b_idx;
  logic [DATA_W-1:0] w_a_old;
  logic [DATA_W-1:0] w_b_old;
  logic [DATA_W-1:0] w_a_new;
  logic [DATA_W-1:0] w_b_new;

  // Init sequencer: INIT clears one word per cycle, then RUN.
  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      r_top <= INIT;
      r_cnt <= '0;
    end else begin
      r_top <= w_top_nxt;
      if (r_top == INIT && r_cnt != C_LAST) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_top_nxt = r_top;
    if (r_top == INIT && r_cnt == C_LAST) begin
      w_top_nxt = RUN;
    end
  end

  assign w_run         = (r_top == RUN) && !ram_rst;
  assign ram_init_busy = ram_rst || (r_top == INIT);

  ram_dp_port_ctrl #(.WAIT_STATES(WAIT_STATES)) u_ctrl_a (
    .clk      (ram_clk),
    .rst      (ram_rst),
    .i_run    (w_run),
    .i_cen    (ram_a.cen),
    .o_ready  (w_a_ready),
    .o_commit (w_a_commit)
  );

  ram_dp_port_ctrl #(.WAIT_STATES(WAIT_STATES)) u_ctrl_b (
    .clk      (ram_clk),
    .rst      (ram_rst),
    .i_run    (w_run),
    .i_cen    (ram_b.cen),
    .o_ready  (w_b_ready),
    .o_commit (w_b_commit)
  );

  assign ram_a.ready = w_a_ready;
  assign ram_b.ready = w_b_ready;

  // Upper address bits only matter for the range check.
  assign w_a_addr = ram_a.addr;
  assign w_b_addr = ram_b.addr;
  assign w_a_inr  = (32'(w_a_addr) < 32'(DEPTH));
  assign w_b_inr  = (32'(w_b_addr) < 32'(DEPTH));
  assign w_a_idx  = CNT_W'(w_a_addr);
  assign w_b_idx  = CNT_W'(w_b_addr);
  assign w_a_old  = r_mem[w_a_idx];
  assign w_b_old  = r_mem[w_b_idx];
  assign w_a_wr   = w_a_commit && w_a_inr && !(&ram_a.wen);
  assign w_b_wr   = w_b_commit && w_b_inr && !(&ram_b.wen);
  assign w_same   = (w_a_addr == w_b_addr);

  // Both ports see the same merged word on a same-address hit; A owns its lanes.
  always_comb begin
    w_a_new = w_a_old;
    w_b_new = w_b_old;
    for (int i = 0; i < BYTES; i++) begin
      if (!ram_a.wen[i]) begin
        w_a_new[8*i +: 8] = ram_a.din[8*i +: 8];
      end else if (w_same && w_b_wr && !ram_b.wen[i]) begin
        w_a_new[8*i +: 8] = ram_b.din[8*i +: 8];
      end
      if (w_same && w_a_wr && !ram_a.wen[i]) begin
        w_b_new[8*i +: 8] = ram_a.din[8*i +: 8];
      end else if (!ram_b.wen[i]) begin
        w_b_new[8*i +: 8] = ram_b.din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge ram_clk) begin
    if (r_top == INIT) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (w_a_wr) begin
        r_mem[w_a_idx] <= w_a_new;
      end
      if (w_b_wr && !(w_a_wr && w_same)) begin
        r_mem[w_b_idx] <= w_b_new;
      end
    end
  end

  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      r_a_dout <= '0;
      r_b_dout <= '0;
    end else begin
      if (w_a_commit) begin
        r_a_dout <= w_a_inr ? w_a_new : '0;
      end
      if (w_b_commit) begin
        r_b_dout <= w_b_inr ? w_b_new : '0;
      end
    end
  end

  assign ram_a.dout = r_a_dout;
  assign ram_b.dout = r_b_dout;

`ifdef RAM_DP_COLLISION_CHK_EN
  logic r_coll;

  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      r_coll <= 1'b0;
    end else if (w_a_wr && w_b_wr && w_same && |(~ram_a.wen & ~ram_b.wen)) begin
      r_coll <= 1'b1;
    end
  end

  assign ram_coll_err = r_coll;
`else
  assign ram_coll_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_dp.sv
`default_nettype none
// =============================================================================
// tb_ram_dp : scoreboard bench for ram_dp (zero-wait and 3-wait instances)
// Rev 1.0
// =============================================================================
module tb_ram_dp;

  logic clk = 1'b0;
  logic rst0;
  logic rst3;
  logic busy0, busy3, coll0, coll3;
  int   n_run  = 0;
  int   n_fail = 0;

  logic [15:0] exp_a0[$];
  logic [15:0] exp_b0[$];
  logic [15:0] exp_a3[$];
  logic [15:0] exp_b3[$];

  ram_dp_if #(.ADDR_MSB(6), .DATA_W(16)) a0 ();
  ram_dp_if #(.ADDR_MSB(6), .DATA_W(16)) b0 ();
  ram_dp_if #(.ADDR_MSB(7), .DATA_W(16)) a3 ();
  ram_dp_if #(.ADDR_MSB(7), .DATA_W(16)) b3 ();

  ram_dp #(.ADDR_MSB(6), .MEM_SIZE(256), .DATA_W(16), .WAIT_STATES(0)) u_dut0 (
    .ram_clk       (clk),
    .ram_rst       (rst0),
    .ram_a         (a0),
    .ram_b         (b0),
    .ram_init_busy (busy0),
    .ram_coll_err  (coll0)
  );

  ram_dp #(.ADDR_MSB(7), .MEM_SIZE(256), .DATA_W(16), .WAIT_STATES(3)) u_dut3 (
    .ram_clk       (clk),
    .ram_rst       (rst3),
    .ram_a         (a3),
    .ram_b         (b3),
    .ram_init_busy (busy3),
    .ram_coll_err  (coll3)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    a0.cen = 1'b1; a0.wen = 2'b11;
    b0.cen = 1'b1; b0.wen = 2'b11;
  endtask

  task automatic idle_all();
    idle0();
    a0.addr = '0; a0.din = '0; b0.addr = '0; b0.din = '0;
    a3.cen = 1'b1; a3.wen = 2'b11; a3.addr = '0; a3.din = '0;
    b3.cen = 1'b1; b3.wen = 2'b11; b3.addr = '0; b3.din = '0;
  endtask

  // Zero-wait instance: drive one access and record its expected dout.
  task automatic drive0(input bit pb, input logic [6:0] addr, input logic [1:0] wen,
                        input logic [15:0] din, input logic [15:0] exp);
    if (pb) begin
      b0.addr = addr; b0.wen = wen; b0.din = din; b0.cen = 1'b0;
      exp_b0.push_back(exp);
    end else begin
      a0.addr = addr; a0.wen = wen; a0.din = din; a0.cen = 1'b0;
      exp_a0.push_back(exp);
    end
  endtask

  // Wait-state instance: hold cen low until the commit edge, report cycles used.
  task automatic p3_access(input bit pb, input logic [7:0] addr, input logic [1:0] wen,
                           input logic [15:0] din, input logic [15:0] exp, output int cyc);
    logic rdy;
    if (pb) begin
      b3.addr = addr; b3.wen = wen; b3.din = din; b3.cen = 1'b0;
      exp_b3.push_back(exp);
    end else begin
      a3.addr = addr; a3.wen = wen; a3.din = din; a3.cen = 1'b0;
      exp_a3.push_back(exp);
    end
    cyc = 0;
    rdy = 1'b0;
    while (!rdy && cyc < 20) begin
      #1;
      rdy = pb ? b3.ready : a3.ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (pb) b3.cen = 1'b1; else a3.cen = 1'b1;
  endtask

  task automatic test_reset();
    int   c0, c3, nz;
    bit   bad;
    logic [15:0] e, g;
    idle_all();
    rst0 = 1'b1; rst3 = 1'b1;
    repeat (3) step();
    n_run++;
    if (busy0 !== 1'b1 || busy3 !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy: busy0=%b busy3=%b expected 1 1", busy0, busy3);
    end
    n_run++;
    if ({a0.ready, b0.ready, a3.ready, b3.ready} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready: ready=%b expected 0000", {a0.ready, b0.ready, a3.ready, b3.ready});
    end
    n_run++;
    if (a0.dout !== 16'h0 || b0.dout !== 16'h0 || coll0 !== 1'b0 || coll3 !== 1'b0) begin
      n_fail++; $display("FAIL reset_dout: a=%h b=%h coll=%b%b expected 0", a0.dout, b0.dout, coll0, coll3);
    end
    rst0 = 1'b0; rst3 = 1'b0;
    c0 = 0; c3 = 0; bad = 1'b0;
    for (int k = 0; k < 400 && (busy0 || busy3); k++) begin
      if (busy0) c0++;
      if (busy3) c3++;
      if ((busy0 && (a0.ready || b0.ready)) || (busy3 && (a3.ready || b3.ready))) bad = 1'b1;
      step();
    end
    n_run++;
    if (c0 !== 128 || c3 !== 128) begin
      n_fail++; $display("FAIL init_len: busy cycles %0d/%0d expected 128", c0, c3);
    end
    n_run++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL init_ready: ready seen during init, expected none");
    end
    n_run++;
    if (a0.ready !== 1'b1 || a3.ready !== 1'b0) begin
      n_fail++; $display("FAIL run_ready: a0=%b a3=%b expected 1 0", a0.ready, a3.ready);
    end
    nz = 0;
    for (int i = 0; i < 128; i++) begin
      drive0(1'b0, 7'(i), 2'b11, 16'h0, 16'h0000);
      step();
      g = a0.dout; e = exp_a0.pop_front();
      if (g !== e) nz++;
    end
    idle0();
    n_run++;
    if (nz !== 0) begin
      n_fail++; $display("FAIL init_clear: %0d nonzero words, expected 0", nz);
    end
  endtask

  task automatic test_write_read();
    bit          pb_t  [6] = '{0, 0, 0, 1, 0, 1};
    logic [1:0]  wen_t [6] = '{2'b00, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11};
    logic [15:0] din_t [6] = '{16'hBEEF, 16'h0, 16'h1234, 16'h0, 16'hAA77, 16'h0};
    logic [15:0] exp_t [6] = '{16'hBEEF, 16'hBEEF, 16'hBE34, 16'hBE34, 16'hAA34, 16'hAA34};
    logic [15:0] g, e;
    for (int i = 0; i < 6; i++) begin
      drive0(pb_t[i], 7'd5, wen_t[i], din_t[i], exp_t[i]);
      step();
      idle0();
      if (pb_t[i]) begin g = b0.dout; e = exp_b0.pop_front(); end
      else         begin g = a0.dout; e = exp_a0.pop_front(); end
      n_run++;
      if (g !== e) begin
        n_fail++; $display("FAIL write_read[%0d]: dout=%h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_collision();
    bit          exp_coll;
    logic [15:0] g, e;
`ifdef RAM_DP_COLLISION_CHK_EN
    exp_coll = 1'b1;
`else
    exp_coll = 1'b0;
`endif
    drive0(1'b0, 7'd9, 2'b10, 16'h1111, 16'h2211);
    drive0(1'b1, 7'd9, 2'b00, 16'h2222, 16'h2211);
    step();
    idle0();
    g = a0.dout; e = exp_a0.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL coll_a_dout: %h expected %h", g, e); end
    g = b0.dout; e = exp_b0.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL coll_b_dout: %h expected %h", g, e); end
    n_run++;
    if (coll0 !== exp_coll) begin n_fail++; $display("FAIL coll_flag: %b expected %b", coll0, exp_coll); end
    drive0(1'b0, 7'd9, 2'b11, 16'h0, 16'h3311);
    drive0(1'b1, 7'd9, 2'b01, 16'h3333, 16'h3311);
    step();
    idle0();
    g = a0.dout; e = exp_a0.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL rd_during_wr: %h expected %h", g, e); end
    g = b0.dout; e = exp_b0.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL wr_vs_rd_b: %h expected %h", g, e); end
    drive0(1'b0, 7'd10, 2'b00, 16'h0A0A, 16'h0A0A);
    drive0(1'b1, 7'd11, 2'b00, 16'h0B0B, 16'h0B0B);
    step();
    drive0(1'b0, 7'd11, 2'b11, 16'h0, 16'h0B0B);
    drive0(1'b1, 7'd10, 2'b11, 16'h0, 16'h0A0A);
    step();
    idle0();
    void'(exp_a0.pop_front());
    void'(exp_b0.pop_front());
    g = a0.dout; e = exp_a0.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL dual_wr_a: %h expected %h", g, e); end
    g = b0.dout; e = exp_b0.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL dual_wr_b: %h expected %h", g, e); end
    n_run++;
    if (coll0 !== exp_coll) begin n_fail++; $display("FAIL coll_sticky: %b expected %b", coll0, exp_coll); end
  endtask

  task automatic test_wait_states();
    int          cyc;
    logic [3:0]  trace;
    logic [15:0] g, e;
    p3_access(1'b0, 8'd7, 2'b00, 16'hA5C3, 16'hA5C3, cyc);
    n_run++;
    if (cyc !== 4) begin n_fail++; $display("FAIL ws_write_cyc: %0d expected 4", cyc); end
    g = a3.dout; e = exp_a3.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL ws_write_dout: %h expected %h", g, e); end
    b3.addr = 8'd7; b3.wen = 2'b11; b3.din = 16'h0; b3.cen = 1'b0;
    exp_b3.push_back(16'hA5C3);
    trace = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      trace[k] = b3.ready;
      if (k == 3) begin
        n_run++;
        if (b3.dout !== 16'h0000) begin n_fail++; $display("FAIL ws_dout_early: %h expected 0000", b3.dout); end
      end
      step();
    end
    b3.cen = 1'b1;
    n_run++;
    if (trace !== 4'b1000) begin n_fail++; $display("FAIL ws_ready_seq: %b expected 1000 (msb=4th cycle)", trace); end
    g = b3.dout; e = exp_b3.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL ws_read_dout: %h expected %h", g, e); end
    p3_access(1'b0, 8'd7, 2'b00, 16'h0F0F, 16'h0F0F, cyc);
    void'(exp_a3.pop_front());
    b3.addr = 8'd7; b3.wen = 2'b11; b3.cen = 1'b0;
    step();
    step();
    b3.cen = 1'b1;
    repeat (3) step();
    n_run++;
    if (b3.dout !== 16'hA5C3 || b3.ready !== 1'b0) begin
      n_fail++; $display("FAIL ws_abort: dout=%h ready=%b expected a5c3 0", b3.dout, b3.ready);
    end
    p3_access(1'b1, 8'd7, 2'b11, 16'h0, 16'h0F0F, cyc);
    g = b3.dout; e = exp_b3.pop_front(); n_run++;
    if (g !== e || cyc !== 4) begin
      n_fail++; $display("FAIL ws_after_abort: dout=%h cyc=%0d expected %h 4", g, cyc, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  addr_t [3] = '{8'd7, 8'd8, 8'd7};
    logic [15:0] exp_t  [3] = '{16'h0F0F, 16'h0000, 16'h0F0F};
    int          cyc;
    logic [15:0] g, e;
    for (int i = 0; i < 3; i++) begin
      p3_access(1'b1, addr_t[i], 2'b11, 16'h0, exp_t[i], cyc);
      g = b3.dout; e = exp_b3.pop_front(); n_run++;
      if (g !== e || cyc !== 4) begin
        n_fail++; $display("FAIL b2b[%0d]: dout=%h cyc=%0d expected %h 4", i, g, cyc, e);
      end
    end
  endtask

  task automatic test_out_of_range();
    int          cyc;
    logic [15:0] g, e;
    p3_access(1'b0, 8'd72, 2'b00, 16'h7272, 16'h7272, cyc);
    g = a3.dout; e = exp_a3.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL oor_wr72: %h expected %h", g, e); end
    p3_access(1'b1, 8'd200, 2'b00, 16'hDEAD, 16'h0, cyc);
    void'(exp_b3.pop_front());
    p3_access(1'b0, 8'd200, 2'b11, 16'h0, 16'h0000, cyc);
    g = a3.dout; e = exp_a3.pop_front(); n_run++;
    if (g !== e || cyc !== 4) begin
      n_fail++; $display("FAIL oor_rd200: dout=%h cyc=%0d expected %h 4", g, cyc, e);
    end
    p3_access(1'b0, 8'd72, 2'b11, 16'h0, 16'h7272, cyc);
    g = a3.dout; e = exp_a3.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL oor_alias72: %h expected %h", g, e); end
  endtask

  task automatic test_reset_mid();
    int          c0, nz;
    logic [15:0] g, e;
    logic [6:0]  chk_t [3] = '{7'd5, 7'd9, 7'd100};
    drive0(1'b0, 7'd100, 2'b00, 16'h6464, 16'h6464);
    step();
    idle0();
    g = a0.dout; e = exp_a0.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL rm_wr100: %h expected %h", g, e); end
    for (int pass = 0; pass < 2; pass++) begin
      rst0 = 1'b1;
      step();
      rst0 = 1'b0;
      if (pass == 0) begin
        repeat (60) step();
        rst0 = 1'b1;
        step();
        rst0 = 1'b0;
      end
      n_run++;
      if (a0.dout !== 16'h0 || coll0 !== 1'b0 || busy0 !== 1'b1) begin
        n_fail++; $display("FAIL rm_state[%0d]: dout=%h coll=%b busy=%b expected 0 0 1", pass, a0.dout, coll0, busy0);
      end
      c0 = 0;
      for (int k = 0; k < 400 && busy0; k++) begin
        c0++;
        step();
      end
      n_run++;
      if (c0 !== 128) begin n_fail++; $display("FAIL rm_init_len[%0d]: %0d expected 128", pass, c0); end
      if (pass == 0) begin
        for (int i = 0; i < 3; i++) begin
          drive0(1'b1, chk_t[i], 2'b11, 16'h0, 16'h0000);
          step();
          idle0();
          g = b0.dout; e = exp_b0.pop_front(); n_run++;
          if (g !== e) begin n_fail++; $display("FAIL rm_clear[%0d]: %h expected %h", i, g, e); end
        end
        drive0(1'b0, 7'd100, 2'b00, 16'h6464, 16'h6464);
        step();
        drive0(1'b0, 7'd100, 2'b11, 16'h0, 16'h6464);
        step();
        idle0();
        void'(exp_a0.pop_front());
        g = a0.dout; e = exp_a0.pop_front(); n_run++;
        if (g !== e) begin n_fail++; $display("FAIL rm_rewrite: %h expected %h", g, e); end
      end
    end
    nz = 0;
    for (int i = 0; i < 128; i++) begin
      drive0(1'b0, 7'(i), 2'b11, 16'h0, 16'h0000);
      step();
      g = a0.dout; e = exp_a0.pop_front();
      if (g !== e) nz++;
    end
    idle0();
    n_run++;
    if (nz !== 0) begin n_fail++; $display("FAIL rm_all_zero: %0d nonzero words expected 0", nz); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1'b1;
    rst3 = 1'b1;
    idle_all();
    #1;
    test_reset();
    test_write_read();
    test_collision();
    test_wait_states();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
